// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the four-digit BCD stopwatch.
// Holds the FSM encoding, digit geometry and the combinational BCD incrementer.
package stopwatch_bcd_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int DISP_W     = DIGIT_W * NUM_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_MAX = digit_t'(9);

    typedef struct packed {
        logic [DISP_W-1:0] digits;
        logic              wrap;
    } bcd_inc_t;

    // Ripple a +1 through the digits; any nibble at or above 9 rolls to 0,
    // so a corrupted nibble can never persist above 9.
    function automatic bcd_inc_t bcd_inc(input logic [DISP_W-1:0] cur);
        bcd_inc_t res;
        logic     carry;
        digit_t   d;
        res   = '0;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = cur[i*DIGIT_W +: DIGIT_W];
            if (carry) begin
                if (d >= DIGIT_MAX) begin
                    d     = '0;
                    carry = 1'b1;
                end else begin
                    d     = d + 1'b1;
                    carry = 1'b0;
                end
            end
            res.digits[i*DIGIT_W +: DIGIT_W] = d;
        end
        res.wrap = carry;
        return res;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_btn.sv
// Button conditioner: 2-flop synchronizer, level debouncer, registered rising-edge press pulse.
// Press appears DEBOUNCE+2 cycles after the raw level settles; a button held through reset never pulses.
module btn_cond #(
    parameter int DEBOUNCE = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       fill_q,  fill_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;
    logic             accept;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        fill_d  = {fill_q[0], 1'b1};
        accept  = (sync2_q != level_q) && (cnt_q == CNT_LAST);

        if ((sync2_q == level_q) || accept) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        level_d = accept ? sync2_q : level_q;

        // Only arm once a genuine post-reset low has been seen, so a button
        // already held when reset drops does not count as a press.
        armed_d = armed_q | (fill_q[1] & ~sync2_q & ~level_q);
        press_d = armed_q & accept & sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch with start/stop and clear buttons.
// Digits update one cycle after each prescaler tick; running follows the state register directly.
module stopwatch_bcd
    import stopwatch_bcd_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int DEBOUNCE = 500_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_clear,
    output logic [DISP_W-1:0] digits,
    output logic              running,
    output logic              wrap
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic start_pls;
    logic clear_pls;

    btn_cond #(.DEBOUNCE(DEBOUNCE)) u_start (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_start),
        .press   (start_pls)
    );

    btn_cond #(.DEBOUNCE(DEBOUNCE)) u_clear (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_clear),
        .press   (clear_pls)
    );

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [DISP_W-1:0] digits_q, digits_d;
    logic              wrap_q, wrap_d;
    logic              tick;
    bcd_inc_t          inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear outranks start in every state.
    always_comb begin
        state_d = state_q;
        if (clear_pls) begin
            state_d = ST_IDLE;
        end else if (start_pls) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state_q == ST_RUN);
        tick    = running && (presc_q == PRE_LAST);
    end

    assign inc = bcd_inc(digits_q);

    // PAUSE falls through with everything held, so RUN resumes mid-period.
    always_comb begin
        presc_d  = presc_q;
        digits_d = digits_q;
        wrap_d   = 1'b0;
        if (clear_pls || (state_q == ST_IDLE)) begin
            presc_d  = '0;
            digits_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                digits_d = inc.digits;
                wrap_d   = inc.wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            digits_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            digits_q <= digits_d;
            wrap_q   <= wrap_d;
        end
    end

    assign digits = digits_q;
    assign wrap   = wrap_q;

endmodule
